// File: rtl/bfp16_result_checker.sv
// bfp16_result_checker: in-order response checker for the BFP16 multiplier.
// Expected products are queued as they are pushed. Each result is compared
// against the oldest queued value. Pass/fail counts accumulate, the first
// failure is captured, and done is raised after a programmed number of results.
// Optional build macro: BFP16_CHK_NAN_EQUIV_EN (any NaN matches any NaN).
module bfp16_result_checker #(
  parameter int unsigned DATA_TYPE  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_tests,
  input  logic                 exp_valid,
  input  logic [DATA_TYPE-1:0] exp_data,
  input  logic                 res_valid,
  input  logic [DATA_TYPE-1:0] res_data,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 err_flag,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [DATA_TYPE-1:0] first_err_got,
  output logic [DATA_TYPE-1:0] first_err_exp,
  output logic                 overflow,
  output logic                 underrun
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_TYPE-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_TYPE-1:0]   mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]       num_tests_q, num_tests_d;
  logic [CNT_W-1:0]       pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;
  logic                   err_flag_q, err_flag_d;
  logic [CNT_W-1:0]       first_err_idx_q, first_err_idx_d;
  logic [DATA_TYPE-1:0]   first_err_got_q, first_err_got_d;
  logic [DATA_TYPE-1:0]   first_err_exp_q, first_err_exp_d;
  logic                   overflow_q, overflow_d;
  logic                   underrun_q, underrun_d;

  logic                   clear, res_take, q_empty, q_full, pop, push_ok;
  logic                   is_match, got_fail;
  logic [DATA_TYPE-1:0]   head;
  logic [CNT_W-1:0]       res_idx;
  logic [PtrW-1:0]        wr_base, rd_base;
  logic [OccW-1:0]        occ_base;

`ifdef BFP16_CHK_NAN_EQUIV_EN
  // Takes the word without its sign bit: NaN-ness ignores sign.
  function automatic logic is_nan(input logic [14:0] w);
    return (w[14:7] == 8'hFF) && (w[6:0] != 7'd0);
  endfunction
`endif

  // Queue control, comparison and status next-state.
  always_comb begin
    state_d         = state_q;
    mem_d           = mem_q;
    num_tests_d     = num_tests_q;
    pass_cnt_d      = pass_cnt_q;
    fail_cnt_d      = fail_cnt_q;
    err_flag_d      = err_flag_q;
    first_err_idx_d = first_err_idx_q;
    first_err_got_d = first_err_got_q;
    first_err_exp_d = first_err_exp_q;
    overflow_d      = overflow_q;
    underrun_d      = underrun_q;

    clear    = start && (state_q != StRun);
    res_take = (state_q == StRun) && res_valid;
    q_empty  = (occ_q == '0);
    q_full   = (occ_q == OccW'(FIFO_DEPTH));
    pop      = res_take && !q_empty;
    // A clearing start empties the queue first, so a same-cycle push always fits.
    push_ok  = exp_valid && (clear || !q_full || pop);
    head     = mem_q[rd_ptr_q];
    res_idx  = pass_cnt_q + fail_cnt_q;

`ifdef BFP16_CHK_NAN_EQUIV_EN
    is_match = (res_data == head) ||
               (is_nan(res_data[14:0]) && is_nan(head[14:0]));
`else
    is_match = (res_data == head);
`endif
    got_fail = q_empty || !is_match;

    wr_base  = clear ? '0 : wr_ptr_q;
    rd_base  = clear ? '0 : rd_ptr_q;
    occ_base = clear ? '0 : occ_q;
    wr_ptr_d = wr_base + PtrW'(push_ok);
    rd_ptr_d = rd_base + PtrW'(pop);
    occ_d    = occ_base + OccW'(push_ok) - OccW'(pop);
    if (push_ok) begin
      mem_d[wr_base] = exp_data;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pass_cnt_d      = '0;
          fail_cnt_d      = '0;
          err_flag_d      = 1'b0;
          first_err_idx_d = '0;
          first_err_got_d = '0;
          first_err_exp_d = '0;
          overflow_d      = 1'b0;
          underrun_d      = 1'b0;
          num_tests_d     = num_tests;
          state_d         = (num_tests == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (res_take) begin
          if (got_fail) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
            if (!err_flag_q) begin
              err_flag_d      = 1'b1;
              first_err_idx_d = res_idx;
              first_err_got_d = res_data;
              first_err_exp_d = q_empty ? '0 : head;
            end
          end else begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end
          if (q_empty) begin
            underrun_d = 1'b1;
          end
          if (res_idx + CNT_W'(1) == num_tests_q) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropped push: queue full and nothing leaving this cycle.
    if (exp_valid && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      num_tests_q     <= '0;
      pass_cnt_q      <= '0;
      fail_cnt_q      <= '0;
      err_flag_q      <= 1'b0;
      first_err_idx_q <= '0;
      first_err_got_q <= '0;
      first_err_exp_q <= '0;
      overflow_q      <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      num_tests_q     <= num_tests_d;
      pass_cnt_q      <= pass_cnt_d;
      fail_cnt_q      <= fail_cnt_d;
      err_flag_q      <= err_flag_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_got_q <= first_err_got_d;
      first_err_exp_q <= first_err_exp_d;
      overflow_q      <= overflow_d;
      underrun_q      <= underrun_d;
    end
  end

  // Queue storage; occupancy alone decides validity, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy          = (state_q == StRun);
  assign done          = (state_q == StDone);
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;
  assign err_flag      = err_flag_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_got = first_err_got_q;
  assign first_err_exp = first_err_exp_q;
  assign overflow      = overflow_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_bfp16_result_checker.sv
// Testbench for bfp16_result_checker: directed table, hand-written corner
// sequences and randomized runs checked against a queue-based reference model.
module tb_bfp16_result_checker;

  localparam int unsigned DW = 16;
  localparam int unsigned FD = 8;
  localparam int unsigned CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_tests = '0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          res_valid = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic          busy, done, err_flag, overflow, underrun;
  logic [CW-1:0] pass_cnt, fail_cnt, first_err_idx;
  logic [DW-1:0] first_err_got, first_err_exp;

  bfp16_result_checker #(.DATA_TYPE(DW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_flag(err_flag), .first_err_idx(first_err_idx),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp),
    .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_pass = 0;
  string cur_tag = "init";

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Reference model: mode 0 idle, 1 running, 2 finished.
  int            m_mode, m_n, m_pass, m_fail;
  bit            m_err, m_ovf, m_und;
  int            m_idx;
  logic [DW-1:0] m_got, m_exp;
  logic [DW-1:0] mq[$];

  function automatic bit ref_nan(input logic [DW-1:0] w);
    return (w[14:7] == 8'hFF) && (w[6:0] != 0);
  endfunction

  function automatic bit ref_match(input logic [DW-1:0] e, input logic [DW-1:0] g);
`ifdef BFP16_CHK_NAN_EQUIV_EN
    if (ref_nan(e) && ref_nan(g)) return 1'b1;
`endif
    return e == g;
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_err = 0; m_ovf = 0; m_und = 0;
    m_idx = 0; m_got = '0; m_exp = '0;
    mq.delete();
  endtask

  task automatic model_fail(input logic [DW-1:0] g, input logic [DW-1:0] e);
    if (!m_err) begin
      m_err = 1; m_idx = m_pass + m_fail; m_got = g; m_exp = e;
    end
    m_fail++;
  endtask

  task automatic model_step(input bit s, input int n, input bit pv, input logic [DW-1:0] pd,
                            input bit rv, input logic [DW-1:0] rd);
    logic [DW-1:0] e;
    if (s && m_mode != 1) begin
      model_clear();
      m_n = n;
      m_mode = (n == 0) ? 2 : 1;
    end else if (m_mode == 1 && rv) begin
      if (mq.size() == 0) begin
        m_und = 1;
        model_fail(rd, '0);
      end else begin
        e = mq.pop_front();
        if (ref_match(e, rd)) m_pass++;
        else model_fail(rd, e);
      end
      if (m_pass + m_fail == m_n) m_mode = 2;
    end
    if (pv) begin
      if (mq.size() < FD) mq.push_back(pd);
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    check({cur_tag, ".busy"}, 32'(busy), 32'(m_mode == 1));
    check({cur_tag, ".done"}, 32'(done), 32'(m_mode == 2));
    check({cur_tag, ".pass_cnt"}, 32'(pass_cnt), 32'(m_pass));
    check({cur_tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    check({cur_tag, ".err_flag"}, 32'(err_flag), 32'(m_err));
    check({cur_tag, ".first_err_idx"}, 32'(first_err_idx), 32'(m_idx));
    check({cur_tag, ".first_err_got"}, 32'(first_err_got), 32'(m_got));
    check({cur_tag, ".first_err_exp"}, 32'(first_err_exp), 32'(m_exp));
    check({cur_tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({cur_tag, ".underrun"}, 32'(underrun), 32'(m_und));
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit s, input int n, input bit pv, input logic [DW-1:0] pd,
                      input bit rv, input logic [DW-1:0] rd);
    start = s; num_tests = CW'(n); exp_valid = pv; exp_data = pd;
    res_valid = rv; res_data = rd;
    @(posedge clk);
    #1;
    start = 0; exp_valid = 0; res_valid = 0;
    model_step(s, n, pv, pd, rv, rd);
    check_all();
  endtask

  task automatic start_run(input int n);     step(1, n, 0, '0, 0, '0); endtask
  task automatic push(input logic [DW-1:0] d);   step(0, 0, 1, d, 0, '0); endtask
  task automatic result(input logic [DW-1:0] d); step(0, 0, 0, '0, 1, d); endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_mode = 0; m_n = 0;
    model_clear();
    check_all();
  endtask

  typedef struct {
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    bit            pass_strict;
    bit            pass_nan;
  } cmp_vec_t;

  cmp_vec_t tbl[8];

  initial begin
    bit            exp_pass;
    int            n, cyc;
    bit            s, pv, rv;
    logic [DW-1:0] pd, rd;

    tbl[0] = '{16'h3F80, 16'h3F80, 1'b1, 1'b1};
    tbl[1] = '{16'h3F80, 16'h3F81, 1'b0, 1'b0};
    tbl[2] = '{16'h0000, 16'h8000, 1'b0, 1'b0};
    tbl[3] = '{16'h7FC1, 16'hFFC0, 1'b0, 1'b1};
    tbl[4] = '{16'h7F80, 16'hFF80, 1'b0, 1'b0};
    tbl[5] = '{16'h7F80, 16'h7F80, 1'b1, 1'b1};
    tbl[6] = '{16'h7FC0, 16'h7F80, 1'b0, 1'b0};
    tbl[7] = '{16'h7F81, 16'h7F81, 1'b1, 1'b1};

    cur_tag = "reset";
    do_reset();

    cur_tag = "basic3";
    start_run(3);
    check("basic3.busy_after_start", 32'(busy), 32'd1);
    push(16'h3F80); push(16'h4000); push(16'h4040);
    result(16'h3F80); result(16'h4000); result(16'h4040);
    check("basic3.pass", 32'(pass_cnt), 32'd3);
    check("basic3.fail", 32'(fail_cnt), 32'd0);
    check("basic3.done", 32'(done), 32'd1);
    check("basic3.err", 32'(err_flag), 32'd0);

    cur_tag = "mismatch";
    start_run(2);
    push(16'h3C00); push(16'h2060);
    result(16'h3C00); result(16'h2061);
    check("mismatch.pass", 32'(pass_cnt), 32'd1);
    check("mismatch.fail", 32'(fail_cnt), 32'd1);
    check("mismatch.idx", 32'(first_err_idx), 32'd1);
    check("mismatch.got", 32'(first_err_got), 32'h2061);
    check("mismatch.exp", 32'(first_err_exp), 32'h2060);

    cur_tag = "underrun";
    start_run(1);
    result(16'h0040);
    check("underrun.flag", 32'(underrun), 32'd1);
    check("underrun.fail", 32'(fail_cnt), 32'd1);
    check("underrun.exp0", 32'(first_err_exp), 32'd0);
    check("underrun.done", 32'(done), 32'd1);

    cur_tag = "start_in_done_with_res";
    step(1, 2, 0, '0, 1, 16'h1234);
    check("restart.pass", 32'(pass_cnt), 32'd0);
    check("restart.fail", 32'(fail_cnt), 32'd0);
    check("restart.busy", 32'(busy), 32'd1);

    cur_tag = "push_and_res_on_empty";
    step(0, 0, 1, 16'h1111, 1, 16'h1111);
    check("pe.underrun", 32'(underrun), 32'd1);
    check("pe.fail", 32'(fail_cnt), 32'd1);
    result(16'h1111);
    check("pe.pass_stored", 32'(pass_cnt), 32'd1);
    check("pe.done", 32'(done), 32'd1);

    cur_tag = "overflow";
    start_run(8);
    for (int i = 0; i < 9; i++) begin
      push(DW'(16'h4100 + i));
      if (i == 7) check("ovf.not_yet", 32'(overflow), 32'd0);
    end
    check("ovf.ninth", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) result(DW'(16'h4100 + i));
    check("ovf.pass8", 32'(pass_cnt), 32'd8);
    check("ovf.done", 32'(done), 32'd1);

    cur_tag = "full_push_pop";
    start_run(9);
    for (int i = 0; i < 8; i++) push(DW'(16'h5000 + i));
    step(0, 0, 1, 16'h5008, 1, 16'h5000);
    check("fpp.no_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 9; i++) result(DW'(16'h5000 + i));
    check("fpp.pass9", 32'(pass_cnt), 32'd9);

    cur_tag = "table";
    foreach (tbl[i]) begin
`ifdef BFP16_CHK_NAN_EQUIV_EN
      exp_pass = tbl[i].pass_nan;
`else
      exp_pass = tbl[i].pass_strict;
`endif
      start_run(1);
      push(tbl[i].e);
      result(tbl[i].g);
      check($sformatf("table[%0d].pass", i), 32'(pass_cnt), 32'(exp_pass));
      check($sformatf("table[%0d].fail", i), 32'(fail_cnt), 32'(!exp_pass));
    end

    cur_tag = "midrun_reset";
    start_run(5);
    for (int i = 0; i < 5; i++) push(DW'(16'h3000 + i));
    result(16'h3000); result(16'h3001);
    do_reset();
    check("mrr.busy", 32'(busy), 32'd0);
    check("mrr.done", 32'(done), 32'd0);
    check("mrr.pass", 32'(pass_cnt), 32'd0);
    start_run(0);
    check("mrr.zero_done", 32'(done), 32'd1);
    check("mrr.zero_busy", 32'(busy), 32'd0);

    cur_tag = "random";
    for (int run = 0; run < 25; run++) begin
      n = $urandom_range(1, 12);
      start_run(n);
      cyc = 0;
      while (m_mode == 1 && cyc < 300) begin
        s  = ($urandom_range(0, 9) == 0);
        pv = $urandom_range(0, 1) == 1;
        pd = DW'($urandom);
        if ($urandom_range(0, 3) == 0) pd = {pd[15], 8'hFF, (pd[6:0] == 0) ? 7'h40 : pd[6:0]};
        rv = $urandom_range(0, 2) == 0;
        rd = DW'($urandom);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
          rd = mq[0];
          if (ref_nan(rd) && $urandom_range(0, 1) == 1) rd = {~rd[15], rd[14:7], 7'h01};
        end
        step(s, $urandom_range(0, 5), pv, pd, rv, rd);
        cyc++;
      end
      check("random.terminated", 32'(m_mode != 1), 32'd1);
      step(0, 0, 1, DW'($urandom), 1, DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
